// File: rtl/fp_exe_queue.sv
`default_nettype none
// ============================================================================
// fp_exe_queue : request FIFO feeding a single-issue FP unit, in-order results.
// Optional sticky fflags accumulator: define FP_EXE_QUEUE_FFLAGS_EN.
// Revision: 1.0
// ============================================================================
module fp_exe_queue #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 4,
  parameter int TAG_W = 4,
  parameter int OP_W  = 20
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [3*XLEN-1:0]       req_data,
  input  logic [OP_W+4:0]         req_ctrl,
  input  logic [TAG_W-1:0]        req_tag,
  output logic                    exe_enable,
  output logic [3*XLEN-1:0]       exe_data,
  output logic [OP_W+4:0]         exe_ctrl,
  input  logic                    exe_ready,
  input  logic [XLEN-1:0]         exe_result,
  input  logic [4:0]              exe_flags,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [XLEN-1:0]         rsp_result,
  output logic [4:0]              rsp_flags,
  output logic [TAG_W-1:0]        rsp_tag,
  output logic [$clog2(DEPTH):0]  count
`ifdef FP_EXE_QUEUE_FFLAGS_EN
  ,
  output logic [4:0]              fflags,
  input  logic [0:0]              fflags_clr
`endif
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int CTRL_W = OP_W + 5;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [3*XLEN-1:0] data_mem [DEPTH];
  logic [CTRL_W-1:0] ctrl_mem [DEPTH];
  logic [TAG_W-1:0]  tag_mem  [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [XLEN-1:0]  rsp_result_q, rsp_result_d;
  logic [4:0]       rsp_flags_q, rsp_flags_d;
  logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;

  logic push;
  logic pop;

  assign req_ready = (count_q < DEPTH_C);
  assign push      = req_valid && req_ready;
  assign count     = count_q;

  // Head is only meaningful while the FIFO holds something; zero otherwise.
  assign exe_data = (count_q != '0) ? data_mem[rd_ptr_q] : '0;
  assign exe_ctrl = (count_q != '0) ? ctrl_mem[rd_ptr_q] : '0;

  assign rsp_result = rsp_result_q;
  assign rsp_flags  = rsp_flags_q;
  assign rsp_tag    = rsp_tag_q;

  always_comb begin
    state_d    = state_q;
    exe_enable = 1'b0;
    pop        = 1'b0;
    rsp_valid  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (count_q != '0) begin
          exe_enable = 1'b1;
          state_d    = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (exe_ready) begin
          pop     = 1'b1;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d     = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d     = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d      = count_q + CNT_W'(push) - CNT_W'(pop);
    rsp_result_d = rsp_result_q;
    rsp_flags_d  = rsp_flags_q;
    rsp_tag_d    = rsp_tag_q;
    if (pop) begin
      rsp_result_d = exe_result;
      rsp_flags_d  = exe_flags;
      rsp_tag_d    = tag_mem[rd_ptr_q];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
      rsp_tag_q    <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      rsp_result_q <= rsp_result_d;
      rsp_flags_q  <= rsp_flags_d;
      rsp_tag_q    <= rsp_tag_d;
    end
  end

  // Storage needs no reset: it is never observed while count is zero.
  always_ff @(posedge clock) begin
    if (push) begin
      data_mem[wr_ptr_q] <= req_data;
      ctrl_mem[wr_ptr_q] <= req_ctrl;
      tag_mem[wr_ptr_q]  <= req_tag;
    end
  end

`ifdef FP_EXE_QUEUE_FFLAGS_EN
  logic [4:0] fflags_q, fflags_d;
  logic [4:0] hs_flags;

  assign hs_flags = (rsp_valid && rsp_ready) ? rsp_flags_q : 5'd0;

  // A clear coinciding with a handshake keeps only that response's flags.
  always_comb begin
    fflags_d = fflags_q | hs_flags;
    if (fflags_clr[0]) begin
      fflags_d = hs_flags;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      fflags_q <= 5'd0;
    end else begin
      fflags_q <= fflags_d;
    end
  end

  assign fflags = fflags_q;
`endif

endmodule
`default_nettype wire
